// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_pkg
// Description : Shared state encoding and width helpers for reset_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        GAP     = 2'd2,
        DONE    = 2'd3
    } state_e;

    // One spare bit above the largest terminal value so the counter never wraps.
    function automatic int cnt_width(input int min_assert,
                                     input int gap_cycles,
                                     input int timeout_cycles);
        int m;
        m = min_assert;
        if (gap_cycles + 1 > m) m = gap_cycles + 1;
        if (timeout_cycles > m) m = timeout_cycles;
        return $clog2(m) + 1;
    endfunction

    function automatic int idx_width(input int n_dom);
        return (n_dom > 1) ? $clog2(n_dom) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_if
// Description : Reset interface between the sequencer and downstream domains.
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
    parameter int N_DOM = 3
) ();
    logic             soft_req;
    logic [N_DOM-1:0] dom_ready;
    logic [N_DOM-1:0] dom_rst_n;
    logic             busy;
    logic             all_ready;
    logic             err;

    modport master (
        input  soft_req,
        input  dom_ready,
        output dom_rst_n,
        output busy,
        output all_ready,
        output err
    );

    modport slave (
        output soft_req,
        output dom_ready,
        input  dom_rst_n,
        input  busy,
        input  all_ready,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/bit_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync_2ff
// Description : Per-bit two-flop data synchroniser, async reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Ordered reset assertion/release for N_DOM downstream domains.
//               Optional watchdog: define RESET_SEQUENCER_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int N_DOM          = 3,
    parameter int MIN_ASSERT     = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              arst_n,
    reset_sequencer_if.master bus
);
    localparam int c_cnt_w = cnt_width(MIN_ASSERT, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int c_idx_w = idx_width(N_DOM);

    localparam logic [c_cnt_w-1:0] c_assert_last = c_cnt_w'(MIN_ASSERT - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last    = c_cnt_w'(GAP_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_last    = c_idx_w'(N_DOM - 1);

    state_e             r_state, w_state_nxt;
    logic [c_idx_w-1:0] r_idx, w_idx_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [N_DOM-1:0]   r_dom_rst_n, w_dom_rst_n_nxt;
    logic [N_DOM-1:0]   w_rdy_s;
    logic               w_rdy_cur;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    localparam logic [c_cnt_w-1:0] c_wd_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    logic [c_cnt_w-1:0] r_wd, w_wd_nxt;
    logic               r_err, w_err_nxt;
`endif

    bit_sync_2ff #(.WIDTH(N_DOM)) u_rdy_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .d      (bus.dom_ready),
        .q      (w_rdy_s)
    );

    // Loop select keeps the index width legal for any N_DOM, including 1.
    always_comb begin
        w_rdy_cur = 1'b0;
        for (int i = 0; i < N_DOM; i++) begin
            if (r_idx == c_idx_w'(i)) w_rdy_cur = w_rdy_s[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
        w_err_nxt   = r_err;
`endif
        if (bus.soft_req) begin
            w_state_nxt = ASSERT;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ASSERT: begin
                    if (r_cnt == c_assert_last) begin
                        w_state_nxt = RELEASE;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                RELEASE: begin
                    if (w_rdy_cur) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = '0;
                    end
`ifdef RESET_SEQUENCER_WATCHDOG_EN
                    else if (r_wd == c_wd_last) begin
                        w_state_nxt = ASSERT;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_err_nxt   = 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (r_cnt == c_gap_last) begin
                        w_cnt_nxt = '0;
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = RELEASE;
                            w_idx_nxt   = r_idx + c_idx_w'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = ASSERT;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
`ifdef RESET_SEQUENCER_WATCHDOG_EN
        // Any entry into RELEASE comes from another state, so this clears on entry.
        w_wd_nxt = (r_state == RELEASE && w_state_nxt == RELEASE) ? r_wd + c_cnt_w'(1) : '0;
`endif
    end

    // Resets are decoded from the next state so each output flop changes with the FSM.
    always_comb begin
        w_dom_rst_n_nxt = '0;
        for (int i = 0; i < N_DOM; i++) begin
            if (w_state_nxt == DONE) begin
                w_dom_rst_n_nxt[i] = 1'b1;
            end else if ((w_state_nxt == RELEASE || w_state_nxt == GAP) &&
                         (c_idx_w'(i) <= w_idx_nxt)) begin
                w_dom_rst_n_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= ASSERT;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_dom_rst_n <= '0;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
            r_wd        <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dom_rst_n <= w_dom_rst_n_nxt;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
            r_wd        <= w_wd_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign bus.dom_rst_n = r_dom_rst_n;
    assign bus.busy      = (r_state != DONE);
    assign bus.all_ready = (r_state == DONE) && (&w_rdy_s);
`ifdef RESET_SEQUENCER_WATCHDOG_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire
